// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy-encoded state and counter width.
package pipe_pkg;

  localparam int unsigned CNT_W = 2;

  // Encodings equal the occupancy so count can be driven straight from state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stage boundary plus flush and occupancy for the elastic stage register.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);
  import pipe_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/en_reg.sv
// Load-enabled register with synchronous reset and synchronous clear.
module en_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic stage register (main + skid); in_ready depends on state only.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  pipe_skid_reg_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             main_en, skid_en, main_from_skid;
  logic             in_fire, out_fire;

  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_q;
  assign bus.count     = CNT_W'(state_q);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  en_reg #(
    .WIDTH(WIDTH)
  ) u_main (
    .clk(clk),
    .rst(rst),
    .clr(bus.flush),
    .en (main_en),
    .d  (main_d),
    .q  (main_q)
  );

  en_reg #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk(clk),
    .rst(rst),
    .clr(bus.flush),
    .en (skid_en),
    .d  (bus.in_data),
    .q  (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus randomized run against a queue-based FIFO model.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(32)) bus ();

  pipe_skid_reg #(
    .WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_out_data;
    logic [1:0]  exp_count;
    logic        chk_data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic f, input logic iv,
                     input logic [31:0] d, input logic ordy, input logic eir,
                     input logic eov, input logic [31:0] eod, input logic [1:0] ec,
                     input logic cd);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = d;
    v.out_ready = ordy; v.exp_in_ready = eir; v.exp_out_valid = eov;
    v.exp_out_data = eod; v.exp_count = ec; v.chk_data = cd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] d,
                       input logic ordy);
    rst = r; bus.flush = f; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
  endtask

  // Reference model: the stage is a FIFO of at most two words.
  logic [31:0] mq[$];
  logic        zeroed;

  task automatic model_edge(input logic r, input logic f, input logic iv, input logic [31:0] d,
                            input logic ordy);
    bit ifire, ofire;
    ifire = iv && (mq.size() < 2);
    ofire = ordy && (mq.size() > 0);
    if (r || f) begin
      mq.delete();
      zeroed = 1'b1;
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) begin
        mq.push_back(d);
        zeroed = 1'b0;
      end
    end
  endtask

  initial begin
    logic        r, f, iv, ordy, stalled;
    logic [31:0] d, prev_data;

    // Reset state, then AA pulse
    add("reset_state", 0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  2'd0, 1);
    add("aa_accept",   0, 0, 1, 32'hAA, 1, 1, 0, 32'h0,  2'd0, 1);
    add("aa_out",      0, 0, 0, 32'h0,  1, 1, 1, 32'hAA, 2'd1, 1);
    add("aa_drained",  0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  2'd0, 0);
    // Stream 1..8 with no bubbles
    add("stream_1", 0, 0, 1, 32'h1, 1, 1, 0, 32'h0, 2'd0, 0);
    for (int k = 2; k <= 8; k++)
      add($sformatf("stream_%0d", k), 0, 0, 1, 32'(k), 1, 1, 1, 32'(k - 1), 2'd1, 1);
    add("stream_last", 0, 0, 0, 32'h0, 1, 1, 1, 32'h8, 2'd1, 1);
    add("stream_end",  0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 2'd0, 0);
    // Backpressure into skid, then drain
    add("bp_10",    0, 0, 1, 32'h10, 0, 1, 0, 32'h0,  2'd0, 0);
    add("bp_11",    0, 0, 1, 32'h11, 0, 1, 1, 32'h10, 2'd1, 1);
    add("bp_full",  0, 0, 1, 32'h12, 0, 0, 1, 32'h10, 2'd2, 1);
    add("bp_rel",   0, 0, 1, 32'h12, 1, 0, 1, 32'h10, 2'd2, 1);
    add("bp_out11", 0, 0, 1, 32'h12, 1, 1, 1, 32'h11, 2'd1, 1);
    add("bp_out12", 0, 0, 0, 32'h0,  1, 1, 1, 32'h12, 2'd1, 1);
    add("bp_empty", 0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  2'd0, 0);
    // Flush from FULL with a word offered
    add("fl_20",    0, 0, 1, 32'h20, 0, 1, 0, 32'h0,  2'd0, 0);
    add("fl_21",    0, 0, 1, 32'h21, 0, 1, 1, 32'h20, 2'd1, 1);
    add("fl_full",  0, 1, 1, 32'h22, 0, 0, 1, 32'h20, 2'd2, 1);
    add("fl_after", 0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  2'd0, 1);
    // Flush from BUSY while in_ready reads 1: offered word is dropped
    add("fl_23",    0, 0, 1, 32'h23, 0, 1, 0, 32'h0,  2'd0, 1);
    add("fl_busy",  0, 1, 1, 32'h24, 0, 1, 1, 32'h23, 2'd1, 1);
    add("fl_drop",  0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  2'd0, 1);
    // Reset mid-stream with in_valid high
    add("rs_30",    0, 0, 1, 32'h30, 0, 1, 0, 32'h0,  2'd0, 1);
    add("rs_busy",  1, 0, 1, 32'h31, 0, 1, 1, 32'h30, 2'd1, 1);
    add("rs_after", 0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  2'd0, 1);

    drive(1, 0, 0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      @(negedge clk);
      chk({vecs[i].name, ".in_ready"},  32'(bus.in_ready),  32'(vecs[i].exp_in_ready));
      chk({vecs[i].name, ".out_valid"}, 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
      chk({vecs[i].name, ".count"},     32'(bus.count),     32'(vecs[i].exp_count));
      if (vecs[i].chk_data) chk({vecs[i].name, ".out_data"}, bus.out_data, vecs[i].exp_out_data);
      @(posedge clk);
      #1;
    end

    // Randomized run; model starts from the reset state.
    drive(1, 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    mq.delete();
    zeroed  = 1'b1;
    stalled = 1'b0;
    prev_data = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      r    = ($urandom_range(0, 511) == 0);
      f    = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = $urandom;
      drive(r, f, iv, d, ordy);
      @(negedge clk);
      chk("rnd.in_ready",  32'(bus.in_ready),  32'(mq.size() < 2));
      chk("rnd.out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("rnd.count",     32'(bus.count),     32'(mq.size()));
      if (bus.count > 2'd2) chk("rnd.count_max", 32'(bus.count), 32'd2);
      if (mq.size() > 0) chk("rnd.out_data", bus.out_data, mq[0]);
      else if (zeroed) chk("rnd.out_data_zero", bus.out_data, 32'h0);
      if (stalled) chk("rnd.stall_stable", bus.out_data, prev_data);
      stalled   = (mq.size() > 0) && !ordy && !r && !f;
      prev_data = bus.out_data;
      @(posedge clk);
      model_edge(r, f, iv, d, ordy);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
